// File: rtl/jcs_regbank_explorer.sv
// Multi-word register bank with EDIT/FILL/SCAN front panel; state updates one cycle after a click, no backpressure.
// Optional JCS_MODE_WRAP_EN makes prev/next mode clicks wrap around instead of saturating.
module jcs_regbank_explorer #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [DW-1:0] sw_data,
  input  logic [AW-1:0] sw_addr,
  input  logic          set_click,
  input  logic          ena_click,
  input  logic          prev_click,
  input  logic          next_click,
  output logic [1:0]    mode,
  output logic [DW-1:0] led,
  output logic [AW-1:0] cur_addr,
  output logic          busy,
  output logic [31:0]   word
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    M_EDIT = 2'd1,
    M_FILL = 2'd2,
    M_SCAN = 2'd3
  } mode_e;

  mode_e         r_mode;
  mode_e         w_next_mode;
  logic          w_mode_chg;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_q;
  logic [DW-1:0] r_seed;
  logic [AW-1:0] r_ptr;
  logic [CW-1:0] r_tick;
  logic          r_busy;
  logic          r_paused;
  logic [DW-1:0] w_fill_dat;

  assign w_fill_dat = r_seed + DW'(r_ptr);

  // prev has priority over next when both arrive together
  always_comb begin
    w_next_mode = r_mode;
    if (prev_click) begin
      case (r_mode)
        M_FILL:  w_next_mode = M_EDIT;
        M_SCAN:  w_next_mode = M_FILL;
`ifdef JCS_MODE_WRAP_EN
        default: w_next_mode = M_SCAN;
`else
        default: w_next_mode = M_EDIT;
`endif
      endcase
    end else if (next_click) begin
      case (r_mode)
        M_EDIT:  w_next_mode = M_FILL;
        M_FILL:  w_next_mode = M_SCAN;
`ifdef JCS_MODE_WRAP_EN
        default: w_next_mode = M_EDIT;
`else
        default: w_next_mode = M_SCAN;
`endif
      endcase
    end
  end

  assign w_mode_chg = !r_busy && (w_next_mode != r_mode);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_mode   <= M_EDIT;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_q   <= '0;
      r_seed   <= '0;
      r_ptr    <= '0;
      r_tick   <= '0;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode   <= w_next_mode;
      r_ptr    <= '0;
      r_tick   <= '0;
      r_paused <= 1'b0;
    end else begin
      case (r_mode)
        M_EDIT: begin
          if (set_click) r_mem[sw_addr] <= sw_data;
          if (ena_click) r_rd_q <= r_mem[sw_addr];
        end
        M_FILL: begin
          if (r_busy) begin
            r_mem[r_ptr] <= w_fill_dat;
            r_ptr        <= r_ptr + 1'b1;
            if (r_ptr == PTR_LAST) r_busy <= 1'b0;
          end else if (set_click) begin
            r_seed <= sw_data;
            r_ptr  <= '0;
            r_busy <= 1'b1;
          end
        end
        M_SCAN: begin
          if (set_click) r_paused <= !r_paused;
          if (ena_click) begin
            r_ptr  <= '0;
            r_tick <= '0;
          end else if (!r_paused) begin
            if (r_tick == TICK_LAST) begin
              r_tick <= '0;
              r_ptr  <= r_ptr + 1'b1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mode     = r_mode;
    busy     = r_busy;
    led      = r_mem[r_ptr];
    cur_addr = r_ptr;
    word     = " scn";
    case (r_mode)
      M_EDIT: begin
        led      = r_rd_q;
        cur_addr = sw_addr;
        word     = " edt";
      end
      M_FILL: begin
        if (r_busy) led = w_fill_dat;
        word = r_busy ? " bsy" : " fil";
      end
      default: word = r_paused ? " pau" : " scn";
    endcase
  end

endmodule
